irq_pending_collector: RTL and testbench
========================================

# irq_pending_collector

Upstream front end for the 4-to-2 priority encoder. Samples four asynchronous interrupt request lines and detects rising edges or tracks levels per channel. Latches edge requests until software or the downstream handler acknowledges them by encoded index. Drives a masked pending vector straight into the encoder's `in` input, plus a summary request and per-channel sticky overflow flags.

## Interface
- `NUM_IRQ`, default 4: channel count; fixed at 4 to match the encoder width, and other values are unsupported.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `irq_in` input 4: raw request lines, asynchronous to `clk`.
- `mode` input 4: per channel; 1 = rising-edge latched, 0 = level.
- `mask` input 4: per channel; 1 = enabled to output.
- `ack` input 1: one-cycle acknowledge strobe.
- `ack_code` input 2: index of the channel acknowledged; same encoding as encoder `code`.
- `ovf_clr` input 1: clears all overflow flags.
- `pending` output 4: masked pending vector; connects to the encoder `in`.
- `irq_out` output 1: OR of `pending`.
- `overflow` output 4: sticky per channel; set when an edge was lost.

## Operation
- Input stage: `irq_in` is registered into `s0`, and `s0` is registered into `prev`. Per-channel edge is `s0 & ~prev`.
- Raw pending register `raw[3:0]`, updated every cycle per channel:
  - Level channel (`mode`=0): `raw` <= `s0`. `ack` has no effect.
  - Edge channel (`mode`=1):
    - If edge, then `raw` <= 1.
    - Else if `ack` and `ack_code` equals the channel index, then `raw` <= 0.
    - Else `raw` holds.
- Edge and ack on the same channel in the same cycle: set wins, so the new request is not lost.
- `pending` = `raw & mask`. Masking only gates the output: `raw` still latches while the channel is masked, and unmasking exposes a held request immediately.
- Ack semantics:
  - Ack of a non-pending edge channel: no effect, no error.
  - Ack of a masked channel: still clears `raw`.
- Overflow: `overflow[i]` sets when an edge occurs on edge channel i while `raw[i]`=1 and `raw[i]` is not being cleared in that same cycle. It holds until `ovf_clr`; `ovf_clr` and a new overflow in the same cycle leaves the flag set.
- Mode change:
  - Edge to level: `raw` follows `s0` from the next cycle.
  - Level to edge: `raw` keeps its current value until acked.
- `irq_out` is combinational from the `pending` registers; no extra flop.

## Timing
- Reset (async assert, sync release by the system): `s0`, `prev`, `raw` and `overflow` are all 0. `pending`=0, `irq_out`=0, `overflow`=0.
- A line held high through reset release produces exactly one rising edge after release.
- Latency without `IRQ_SYNC_EN`:
  - `irq_in` rising before clock edge k gives `s0`=1 after k and `pending`=1 after k+1 (2 cycles).
  - Level deassertion also takes 2 cycles.
- Latency with `IRQ_SYNC_EN`: 3 cycles in both cases.
- Ack to clear: `ack` sampled at edge k gives `pending` bit 0 after k.
- Minimum detectable pulse: one full `clk` period high. Shorter pulses may be missed; this is by design.

## Configuration
- Macro `IRQ_SYNC_EN`.
- Defined: `s0` is the second flop of a 2-flop synchronizer per line, and all input latencies grow by 1 cycle.
- Undefined: a single input register, for inputs already synchronous to `clk`.

## Structure
- Package `irq_pkg`:
  - `IRQ_NUM` = 4 and `IRQ_CODE_W` = 2.
  - Mode constants `IRQ_MODE_LEVEL` = 0 and `IRQ_MODE_EDGE` = 1.
  - Shared with the encoder and its consumers.
- Sub-module `irq_channel`, one instance per channel. It holds the sampling/sync flops, edge detect, `raw` and `overflow` for a single line.
- The top level decodes `ack_code` into a one-hot ack vector, fans it to the channels, and forms `pending` and `irq_out`.

## Test plan
- Reset with `irq_in`=4'b0000: all outputs 0. Assert `rst` mid-operation with `pending`=4'b1010: all outputs 0 immediately, without waiting for a clock.
- Edge mode, mask 4'b1111: pulse `irq_in[2]` for 1 cycle. `pending`=4'b0100 two cycles later and held; `ack`, `ack_code`=2'b10 gives `pending`=0 next cycle.
- Level mode on channel 0: hold `irq_in[0]` high for 5 cycles, then low. `pending[0]` follows with 2-cycle lag. `ack`, `ack_code`=2'b00 has no effect.
- Channel 3, edge mode: second edge while pending gives `overflow`=4'b1000. An edge coinciding with ack on channel 3 gives `pending[3]` staying 1 with no overflow. `ovf_clr` gives `overflow`=0.
- Mask 4'b0000: pulse channel 1, giving `pending`=0 and `irq_out`=0. Set `mask`=4'b0010, giving `pending`=4'b0010 the same cycle.
- `IRQ_SYNC_EN` build: repeat the edge test and check latency is 3 cycles.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg
// Shared constants for the interrupt front end, the 4-to-2 priority encoder
// and their consumers: channel count, encoded index width, per-channel mode
// values and a helper that turns an acknowledge strobe plus encoded index
// into a one-hot per-channel clear vector.
package irq_pkg;

    localparam int IRQ_NUM    = 4;
    localparam int IRQ_CODE_W = 2;

    localparam logic IRQ_MODE_LEVEL = 1'b0;
    localparam logic IRQ_MODE_EDGE  = 1'b1;

    // One-hot acknowledge vector; all zero when no strobe is present.
    function automatic logic [IRQ_NUM-1:0] irq_ack_decode(
        input logic                  ack,
        input logic [IRQ_CODE_W-1:0] code
    );
        logic [IRQ_NUM-1:0] onehot;
        onehot = '0;
        if (ack) begin
            onehot[code] = 1'b1;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/irq_pending_collector_if.sv
// irq_pending_collector_if
// Bundles the request, configuration, acknowledge and result signals of the
// interrupt pending collector.
//   master : drives irq_in, mode, mask, ack, ack_code, ovf_clr;
//            observes pending, irq_out, overflow
//   slave  : the collector itself (opposite directions)
interface irq_pending_collector_if;
    import irq_pkg::*;

    logic [IRQ_NUM-1:0]    irq_in;
    logic [IRQ_NUM-1:0]    mode;
    logic [IRQ_NUM-1:0]    mask;
    logic                  ack;
    logic [IRQ_CODE_W-1:0] ack_code;
    logic                  ovf_clr;
    logic [IRQ_NUM-1:0]    pending;
    logic                  irq_out;
    logic [IRQ_NUM-1:0]    overflow;

    modport master (
        output irq_in, mode, mask, ack, ack_code, ovf_clr,
        input  pending, irq_out, overflow
    );

    modport slave (
        input  irq_in, mode, mask, ack, ack_code, ovf_clr,
        output pending, irq_out, overflow
    );

endinterface

// File: rtl/irq_channel.sv
// irq_channel
// One interrupt line: input sampling (optionally a 2-flop synchronizer when
// IRQ_SYNC_EN is defined), rising-edge detect, the raw pending bit and the
// sticky overflow flag.
//   clk, rst  : clock, asynchronous active-high reset
//   irq_in    : raw request line
//   mode      : 1 = rising-edge latched, 0 = level
//   ack_hit   : acknowledge addressed to this channel
//   ovf_clr   : clear the overflow flag
//   raw       : unmasked pending state
//   overflow  : sticky, set when an edge arrived while already pending
module irq_channel
    import irq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    input  logic mode,
    input  logic ack_hit,
    input  logic ovf_clr,
    output logic raw,
    output logic overflow
);

    logic s0;
    logic prev;
    logic rise;
    logic lost;

`ifdef IRQ_SYNC_EN
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            s0   <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= irq_in;
            s0   <= meta;
            prev <= s0;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s0   <= irq_in;
            prev <= s0;
        end
    end
`endif

    assign rise = s0 & ~prev;

    // A new edge on an already-pending edge channel is lost, unless the same
    // cycle's ack consumes the old request (the edge then re-arms raw).
    assign lost = (mode == IRQ_MODE_EDGE) & rise & raw & ~ack_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (mode == IRQ_MODE_LEVEL) begin
                raw <= s0;
            end else if (rise) begin
                raw <= 1'b1;
            end else if (ack_hit) begin
                raw <= 1'b0;
            end

            // Set has priority over clear so a simultaneous loss is kept.
            if (lost) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/irq_pending_collector.sv
// irq_pending_collector
// Front end for the 4-to-2 priority encoder: samples four request lines,
// latches rising edges or tracks levels per channel, clears edge requests on
// an encoded acknowledge and drives the masked pending vector to the encoder.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : irq_pending_collector_if.slave
//              in : irq_in, mode, mask, ack, ack_code, ovf_clr
//              out: pending (to encoder in), irq_out, overflow
// Build option: define IRQ_SYNC_EN to put a 2-flop synchronizer on each
// line (input latency grows from 2 to 3 cycles).
module irq_pending_collector
    import irq_pkg::*;
#(
    parameter int NUM_IRQ = IRQ_NUM
)
(
    input  logic                    clk,
    input  logic                    rst,
    irq_pending_collector_if.slave  bus
);

    logic [IRQ_NUM-1:0] ack_vec;
    logic [IRQ_NUM-1:0] raw_vec;
    logic [IRQ_NUM-1:0] ovf_vec;
    logic [IRQ_NUM-1:0] pend;

    assign ack_vec = irq_ack_decode(bus.ack, bus.ack_code);

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_ch
        irq_channel u_ch (
            .clk      (clk),
            .rst      (rst),
            .irq_in   (bus.irq_in[i]),
            .mode     (bus.mode[i]),
            .ack_hit  (ack_vec[i]),
            .ovf_clr  (bus.ovf_clr),
            .raw      (raw_vec[i]),
            .overflow (ovf_vec[i])
        );
    end

    // Mask only gates the output; a held request appears as soon as unmasked.
    assign pend         = raw_vec & bus.mask;
    assign bus.pending  = pend;
    assign bus.irq_out  = |pend;
    assign bus.overflow = ovf_vec;

endmodule

// File: tb/tb_irq_pending_collector.sv
module tb_irq_pending_collector;

`ifdef IRQ_SYNC_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    irq_pending_collector_if bus ();

    irq_pending_collector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: history of sampled line values, newest first.
    // The synchronised view of a line is the sample XL edges old; a rising
    // edge is that view being 1 where the previous view was 0.
    logic [3:0] hist [0:2];
    logic [3:0] m_raw;
    logic [3:0] m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) hist[k] = 4'b0;
            m_raw = 4'b0;
            m_ovf = 4'b0;
        end else begin
            logic [3:0] view, old_view, nraw, novf;
            view     = hist[XL];
            old_view = hist[XL+1];
            nraw = m_raw;
            novf = bus.ovf_clr ? 4'b0 : m_ovf;
            for (int c = 0; c < 4; c++) begin
                bit is_rise, is_ack;
                is_rise = view[c] && !old_view[c];
                is_ack  = bus.ack && (int'(bus.ack_code) == c);
                if (!bus.mode[c]) nraw[c] = view[c];
                else if (is_rise) begin
                    if (m_raw[c] && !is_ack) novf[c] = 1'b1;
                    nraw[c] = 1'b1;
                end else if (is_ack) nraw[c] = 1'b0;
            end
            m_raw = nraw;
            m_ovf = novf;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = bus.irq_in;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_pending",  bus.pending, m_raw & bus.mask);
            chk("cyc_irq_out",  {3'b0, bus.irq_out}, {3'b0, |(m_raw & bus.mask)});
            chk("cyc_overflow", bus.overflow, m_ovf);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(input int ch);
        bus.irq_in[ch] = 1'b1;
        tick(1);
        bus.irq_in[ch] = 1'b0;
    endtask

    task automatic do_ack(input logic [1:0] code);
        bus.ack = 1'b1;
        bus.ack_code = code;
        tick(1);
        bus.ack = 1'b0;
    endtask

    initial begin
        bus.irq_in = 4'b0; bus.mode = 4'b1111; bus.mask = 4'b1111;
        bus.ack = 1'b0; bus.ack_code = 2'b0; bus.ovf_clr = 1'b0;

        // Reset state
        #1;
        chk("rst_pending", bus.pending, 4'b0);
        chk("rst_irq_out", {3'b0, bus.irq_out}, 4'b0);
        chk("rst_overflow", bus.overflow, 4'b0);
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("post_rst_pending", bus.pending, 4'b0);

        // Edge mode, channel 2
        pulse(2);
        chk("edge_early", bus.pending, 4'b0000);
        tick(1 + XL);
        chk("edge_latency", bus.pending, 4'b0100);
        tick(3);
        chk("edge_hold", bus.pending, 4'b0100);
        do_ack(2'b10);
        chk("edge_ack", bus.pending, 4'b0000);

        // Level mode, channel 0
        bus.mode = 4'b1110;
        bus.irq_in[0] = 1'b1;
        tick(1);
        chk("lvl_early", bus.pending, 4'b0000);
        tick(1 + XL);
        chk("lvl_rise", bus.pending, 4'b0001);
        do_ack(2'b00);
        chk("lvl_ack_noeffect", bus.pending, 4'b0001);
        tick(2 - XL);
        bus.irq_in[0] = 1'b0;
        tick(1 + XL);
        chk("lvl_fall_lag", bus.pending, 4'b0001);
        tick(1);
        chk("lvl_fall", bus.pending, 4'b0000);

        // Channel 3 overflow
        bus.mode = 4'b1111;
        pulse(3);
        tick(1 + XL);
        chk("ovf_first", bus.pending, 4'b1000);
        pulse(3);
        tick(1 + XL);
        chk("ovf_set", bus.overflow, 4'b1000);
        bus.ovf_clr = 1'b1; tick(1); bus.ovf_clr = 1'b0;
        chk("ovf_clr", bus.overflow, 4'b0000);
        bus.irq_in[3] = 1'b1; tick(1); bus.irq_in[3] = 1'b0;
        tick(XL);
        do_ack(2'b11);
        chk("ack_edge_pending", bus.pending, 4'b1000);
        chk("ack_edge_no_ovf", bus.overflow, 4'b0000);
        do_ack(2'b11);
        chk("ack_ch3", bus.pending, 4'b0000);
        pulse(3);
        tick(1 + XL);
        bus.irq_in[3] = 1'b1; tick(1); bus.irq_in[3] = 1'b0;
        tick(XL);
        bus.ovf_clr = 1'b1; tick(1); bus.ovf_clr = 1'b0;
        chk("ovf_set_beats_clr", bus.overflow, 4'b1000);
        bus.ovf_clr = 1'b1; tick(1); bus.ovf_clr = 1'b0;
        chk("ovf_clr2", bus.overflow, 4'b0000);
        do_ack(2'b11);
        chk("ack_ch3_b", bus.pending, 4'b0000);

        // Masking
        bus.mask = 4'b0000;
        pulse(1);
        tick(1 + XL);
        chk("mask_pending", bus.pending, 4'b0000);
        chk("mask_irq_out", {3'b0, bus.irq_out}, 4'b0);
        bus.mask = 4'b0010;
        #1;
        chk("unmask_pending", bus.pending, 4'b0010);
        chk("unmask_irq_out", {3'b0, bus.irq_out}, 4'b1);
        bus.mask = 4'b0000;
        do_ack(2'b01);
        bus.mask = 4'b1111;
        #1;
        chk("masked_ack", bus.pending, 4'b0000);

        // Async reset mid-operation with pending 1010
        tick(1);
        bus.irq_in = 4'b1010; tick(1); bus.irq_in = 4'b0000;
        tick(1 + XL);
        chk("pre_rst_pending", bus.pending, 4'b1010);
        rst = 1'b1;
        #1;
        chk("async_rst_pending", bus.pending, 4'b0000);
        chk("async_rst_irq_out", {3'b0, bus.irq_out}, 4'b0);
        chk("async_rst_overflow", bus.overflow, 4'b0000);

        // Line held high through reset release gives exactly one edge
        bus.irq_in = 4'b0001;
        tick(2);
        rst = 1'b0;
        tick(2 + XL);
        chk("held_edge", bus.pending, 4'b0001);
        do_ack(2'b00);
        chk("held_ack", bus.pending, 4'b0000);
        tick(4);
        chk("held_single_edge", bus.pending, 4'b0000);
        bus.irq_in = 4'b0000;
        tick(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
